// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 instruction-format constants.
//   - bit positions of every instruction field
//   - NOP_INSTR (sll $0,$0,0), the pipeline bubble value
//   - opcode constants used by fetch/decode
package mips_pkg;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned SH_HI  = 10;
  localparam int unsigned SH_LO  = 6;
  localparam int unsigned FN_HI  = 5;
  localparam int unsigned FN_LO  = 0;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;
  localparam int unsigned JT_HI  = 25;
  localparam int unsigned JT_LO  = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [5:0] {
    R_TYPE = 6'h00,
    J      = 6'h02,
    BEQ    = 6'h04,
    LW     = 6'h23
  } opcode_e;

endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch-side and decode-side signals of the IF/ID register.
//   slave  : view of the pipeline stage (accepts fetch, drives decode fields)
//   master : view of the surrounding fetch/decode logic
//   in_valid/in_ready/in_instr/in_pc    fetch handshake
//   out_valid/out_ready                 decode handshake
//   opcode..jtarget, pc_plus4           decoded fields of the held instruction
interface if_id_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [25:0]       jtarget;
  logic [DATA_W-1:0] pc_plus4;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
           imm16, jtarget, pc_plus4
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
           imm16, jtarget, pc_plus4
  );
endinterface

// File: rtl/mips_instr_fields.sv
// mips_instr_fields: purely combinational slicer of a MIPS32 instruction word.
//   instr   in  32  instruction word
//   opcode, rs, rt, rd, shamt, funct, imm16, jtarget  out  named fields
module mips_instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jtarget
);

  assign opcode  = instr[OP_HI:OP_LO];
  assign rs      = instr[RS_HI:RS_LO];
  assign rt      = instr[RT_HI:RT_LO];
  assign rd      = instr[RD_HI:RD_LO];
  assign shamt   = instr[SH_HI:SH_LO];
  assign funct   = instr[FN_HI:FN_LO];
  assign imm16   = instr[IMM_HI:IMM_LO];
  assign jtarget = instr[JT_HI:JT_LO];

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode pipeline register with a 2-entry skid buffer.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   flush  in  synchronous discard of every held and in-flight instruction
//   bus    slave modport of if_id_stage_if (fetch handshake in, decoded
//          fields of the main entry out, pc_plus4 = held pc + 4)
module if_id_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  if_id_stage_if.slave    bus
);
  import mips_pkg::*;

  logic              m_valid, s_valid, in_ready_q;
  logic [DATA_W-1:0] m_instr, m_pc, s_instr, s_pc;

  logic              m_valid_d, s_valid_d;
  logic [DATA_W-1:0] m_instr_d, m_pc_d, s_instr_d, s_pc_d;

  logic accept, consume;

  assign accept  = bus.in_valid && in_ready_q;
  assign consume = m_valid && bus.out_ready;

  always_comb begin
    m_valid_d = m_valid;
    m_instr_d = m_instr;
    m_pc_d    = m_pc;
    s_valid_d = s_valid;
    s_instr_d = s_instr;
    s_pc_d    = s_pc;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_instr_d = NOP_INSTR;
      s_instr_d = NOP_INSTR;
      m_pc_d    = '0;
      s_pc_d    = '0;
    end else if (!m_valid || consume) begin
      if (s_valid) begin
        // skid drains into main; a same-cycle accept refills the skid
        m_valid_d = 1'b1;
        m_instr_d = s_instr;
        m_pc_d    = s_pc;
        s_valid_d = accept;
        if (accept) begin
          s_instr_d = bus.in_instr;
          s_pc_d    = bus.in_pc;
        end
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_instr_d = bus.in_instr;
        m_pc_d    = bus.in_pc;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_instr_d = bus.in_instr;
      s_pc_d    = bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      m_instr    <= NOP_INSTR;
      s_instr    <= NOP_INSTR;
      m_pc       <= '0;
      s_pc       <= '0;
    end else begin
      m_valid    <= m_valid_d;
      s_valid    <= s_valid_d;
      // in_ready mirrors the next skid state so it never depends on out_ready
      in_ready_q <= !s_valid_d;
      m_instr    <= m_instr_d;
      s_instr    <= s_instr_d;
      m_pc       <= m_pc_d;
      s_pc       <= s_pc_d;
    end
  end

  logic [5:0]  f_opcode, f_funct;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [15:0] f_imm16;
  logic [25:0] f_jtarget;

  mips_instr_fields u_fields (
    .instr   (m_instr),
    .opcode  (f_opcode),
    .rs      (f_rs),
    .rt      (f_rt),
    .rd      (f_rd),
    .shamt   (f_shamt),
    .funct   (f_funct),
    .imm16   (f_imm16),
    .jtarget (f_jtarget)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = m_valid;
  assign bus.opcode    = f_opcode;
  assign bus.rs        = f_rs;
  assign bus.rt        = f_rt;
  assign bus.rd        = f_rd;
  assign bus.shamt     = f_shamt;
  assign bus.funct     = f_funct;
  assign bus.imm16     = f_imm16;
  assign bus.jtarget   = f_jtarget;
  assign bus.pc_plus4  = m_pc + DATA_W'(4);

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: self-checking bench for if_id_stage.
// A queue of (instr, pc) pairs with capacity 2 models the stage; a negedge
// compare process checks handshake and decoded fields against its head.
module tb_if_id_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  if_id_stage_if #(.DATA_W(32)) bus ();

  if_id_stage #(.DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    else
      npass++;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mq[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy, vld;
    if (!rst_n) begin
      mq.delete();
    end else begin
      rdy = (mq.size() < 2);
      vld = (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (vld && bus.out_ready) void'(mq.pop_front());
        if (bus.in_valid && rdy) mq.push_back({bus.in_instr, bus.in_pc});
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] log_q[$];
  int run = 0;
  int max_run = 0;

  always @(negedge clk) begin : compare
    logic [31:0] f, p;
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
      if (mq.size() > 0) begin
        f = mq[0][63:32];
        p = mq[0][31:0];
        chk("opcode",   32'(bus.opcode),  32'(f >> 26));
        chk("rs",       32'(bus.rs),      (f >> 21) & 32'h1F);
        chk("rt",       32'(bus.rt),      (f >> 16) & 32'h1F);
        chk("rd",       32'(bus.rd),      (f >> 11) & 32'h1F);
        chk("shamt",    32'(bus.shamt),   (f >> 6) & 32'h1F);
        chk("funct",    32'(bus.funct),   f & 32'h3F);
        chk("imm16",    32'(bus.imm16),   f & 32'hFFFF);
        chk("jtarget",  32'(bus.jtarget), f & 32'h03FF_FFFF);
        chk("pc_plus4", bus.pc_plus4,     p + 32'd4);
      end
      if (bus.out_valid && bus.out_ready)
        log_q.push_back({bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct});
      if (bus.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    bit acc;
    int unsigned n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    bus.in_pc    = p;
    do begin
      acc = bus.in_ready;
      cycle();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] tp_instr[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // single pass: lw $8,-4($2)
    bus.out_ready = 1'b0;
    push(32'h8C48_FFFC, 32'h0040_0000);
    idle();
    chk("t2_valid",  32'(bus.out_valid), 32'd1);
    chk("t2_opcode", 32'(bus.opcode),    32'h23);
    chk("t2_rs",     32'(bus.rs),        32'd2);
    chk("t2_rt",     32'(bus.rt),        32'd8);
    chk("t2_imm16",  32'(bus.imm16),     32'h0000_FFFC);
    chk("t2_pc4",    bus.pc_plus4,       32'h0040_0004);

    // asynchronous reset mid-clock, observed before any edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);
    chk("rst_op",    32'(bus.opcode),    32'd0);
    chk("rst_imm",   32'(bus.imm16),     32'd0);
    chk("rst_pc4",   bus.pc_plus4,       32'h0000_0004);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // stall: three instructions with decode blocked
    log_q.delete();
    bus.out_ready = 1'b0;
    push(32'h0000_0000 | 32'h0122_4020, 32'h0000_1000);
    push(32'h1085_0003, 32'h0000_1004);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0800_0123;
    bus.in_pc    = 32'h0000_1008;
    cycle();
    cycle();
    chk("t3_ready", 32'(bus.in_ready),  32'd0);
    chk("t3_op1",   32'(bus.opcode),    32'h00);
    chk("t3_rd1",   32'(bus.rd),        32'd8);
    bus.out_ready = 1'b1;
    push(32'h0800_0123, 32'h0000_1008);
    idle();
    repeat (4) cycle();
    chk("t3_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t3_ord0", log_q[0], 32'h0122_4020);
      chk("t3_ord1", log_q[1], 32'h1085_0003);
      chk("t3_ord2", log_q[2], 32'h0800_0123);
    end

    // throughput: 8 back-to-back
    log_q.delete();
    max_run = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tp_instr[k] = 32'h0022_0020 + (32'(k) << 11);
      push(tp_instr[k], 32'h0000_2000 + 32'(k) * 32'd4);
    end
    idle();
    repeat (4) cycle();
    chk("t4_run",   32'(max_run),      32'd8);
    chk("t4_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8)
      for (int k = 0; k < 8; k++) chk("t4_order", log_q[k], tp_instr[k]);

    // flush with both entries full and an incoming instruction
    bus.out_ready = 1'b0;
    push(32'h8C01_0004, 32'h0000_3000);
    push(32'h8C02_0008, 32'h0000_3004);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h8C03_000C;
    bus.in_pc    = 32'h0000_3008;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_ready", 32'(bus.in_ready),  32'd1);
    log_q.delete();
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("t5_none", 32'(log_q.size()), 32'd0);
    push(32'h8C04_0010, 32'h0000_4000);
    idle();
    repeat (2) cycle();
    chk("t5_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) chk("t5_after", log_q[0], 32'h8C04_0010);

    // pc wrap
    bus.out_ready = 1'b0;
    push(32'h0800_0010, 32'hFFFF_FFFC);
    idle();
    chk("t6_pc4", bus.pc_plus4,       32'h0000_0000);
    chk("t6_op",  32'(bus.opcode),    32'h02);
    chk("t6_jt",  32'(bus.jtarget),   32'h0000_0010);
    bus.out_ready = 1'b1;
    repeat (2) cycle();
    chk("t6_drain", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
